// File: rtl/c2p_pkg.sv
// c2p_pkg: register map, STATUS/CONTROL bit positions and shared types for c2p_unit.
// Optional reverse mode is built only when C2P_P2C_EN is defined.
package c2p_pkg;

  localparam logic [4:0] REG_ID_HI = 5'd0;
  localparam logic [4:0] REG_ID_LO = 5'd1;
  localparam logic [4:0] REG_CTRL  = 5'd2;
  localparam logic [3:0] DATA_SEL  = 4'b1110;

  localparam int ST_FULL  = 15;
  localparam int ST_OVF   = 14;
  localparam int ST_MODE  = 13;
  localparam int ST_RPTR  = 8;
  localparam int ST_WPTR  = 0;
  localparam int ST_PTR_W = 5;

  localparam int CTL_CLR  = 0;
  localparam int CTL_MODE = 1;

  typedef enum logic {
    MODE_C2P = 1'b0,
    MODE_P2C = 1'b1
  } c2p_mode_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c2p_xpose.sv
// c2p_xpose: maps a planar word pointer to its bitplane and the first pixel of its
// 16-pixel group; lane i of that word is pixel o_base+i.
module c2p_xpose
  import c2p_pkg::*;
#(
  parameter int PIXELS = 32,
  parameter int PW     = 5,
  parameter int PXW    = 5
) (
  input  logic [PW-1:0]  i_ptr,
  output logic [2:0]     o_plane,
  output logic [PXW-1:0] o_base
);

  localparam int GPR = PIXELS / 16;

  always_comb begin
    o_plane = 3'(int'(i_ptr) / GPR);
    o_base  = PXW'((int'(i_ptr) % GPR) * 16);
  end

endmodule

// File: rtl/c2p_unit.sv
// c2p_unit: Akiko-compatible chunky-to-planar converter with ID words, STATUS/CONTROL
// and overflow tracking; define C2P_P2C_EN to add the planar-to-chunky mode.
module c2p_unit
  import c2p_pkg::*;
#(
  parameter int          PIXELS = 32,
  parameter int          BPP    = 8,
  parameter logic [15:0] ID_HI  = 16'hC0CA,
  parameter logic [15:0] ID_LO  = 16'hCAFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [5:1]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy
);

  localparam int WIN  = PIXELS / 2;
  localparam int WOUT = PIXELS * BPP / 16;
  localparam int PW   = $clog2(max2(WIN, WOUT));
  localparam int PXW  = $clog2(PIXELS);
  localparam logic [PW-1:0] WIN_LAST  = PW'(WIN - 1);
  localparam logic [PW-1:0] WOUT_LAST = PW'(WOUT - 1);

  logic [BPP-1:0] r_pix     [PIXELS];
  logic [BPP-1:0] w_pix_nxt [PIXELS];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic           r_full, r_ovf;
  c2p_mode_e      w_mode;
  logic           w_data_sel, w_data_wr, w_data_rd, w_ctrl_wr, w_clr, w_mode_chg;
  logic           w_wlast, w_rlast;
  logic [PXW-1:0] w_wpair, w_rbase;
  logic [2:0]     w_rplane;
  logic [7:0]     w_px8;
  logic [15:0]    w_planar, w_rdata, w_status;

  assign w_data_sel = (addr[5:2] == DATA_SEL);
  assign w_data_wr  = cs & wr & w_data_sel;
  assign w_data_rd  = cs & rd & ~wr & w_data_sel;  // write wins on a same-cycle rd+wr
  assign w_ctrl_wr  = cs & wr & (addr == REG_CTRL);
  assign w_clr      = w_ctrl_wr & din[CTL_CLR];
  assign w_wlast    = (w_mode == MODE_P2C) ? (r_wptr == WOUT_LAST) : (r_wptr == WIN_LAST);
  assign w_rlast    = (w_mode == MODE_P2C) ? (r_rptr == WIN_LAST) : (r_rptr == WOUT_LAST);
  assign w_wpair    = PXW'({r_wptr, 1'b0});

`ifdef C2P_P2C_EN
  c2p_mode_e      r_mode;
  logic [2:0]     w_wplane;
  logic [PXW-1:0] w_wbase, w_rpair;

  assign w_mode     = r_mode;
  assign w_mode_chg = w_ctrl_wr & (c2p_mode_e'(din[CTL_MODE]) != r_mode);
  assign w_rpair    = PXW'({r_rptr, 1'b0});

  c2p_xpose #(.PIXELS(PIXELS), .PW(PW), .PXW(PXW)) u_xpose_wr (
    .i_ptr   (r_wptr),
    .o_plane (w_wplane),
    .o_base  (w_wbase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_mode <= MODE_C2P;
    else if (w_ctrl_wr) r_mode <= c2p_mode_e'(din[CTL_MODE]);
  end
`else
  assign w_mode     = MODE_C2P;
  assign w_mode_chg = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_clr | w_mode_chg) begin
      r_wptr <= '0;
      r_rptr <= '0;
      if (w_clr) begin
        r_full <= 1'b0;
        r_ovf  <= 1'b0;
      end
    end else if (w_data_wr) begin
      r_rptr <= '0;
      r_wptr <= w_wlast ? '0 : r_wptr + 1'b1;
      if (w_wlast) r_full <= 1'b1;
      if (r_full)  r_ovf  <= 1'b1;  // this write lands on a block nobody read out
    end else if (w_data_rd) begin
      r_wptr <= '0;
      r_full <= 1'b0;
      r_rptr <= w_rlast ? '0 : r_rptr + 1'b1;
    end
  end

  always_comb begin
    w_pix_nxt = r_pix;
`ifdef C2P_P2C_EN
    if (w_mode == MODE_P2C) begin
      for (int i = 0; i < 16; i++)
        for (int b = 0; b < BPP; b++)
          if (w_wplane == 3'(b)) w_pix_nxt[w_wbase + PXW'(i)][b] = din[15-i];
    end else begin
      w_pix_nxt[w_wpair]            = din[8 +: BPP];
      w_pix_nxt[w_wpair | PXW'(1)]  = din[0 +: BPP];
    end
`else
    w_pix_nxt[w_wpair]           = din[8 +: BPP];
    w_pix_nxt[w_wpair | PXW'(1)] = din[0 +: BPP];
`endif
  end

  // pixel store carries no reset
  always_ff @(posedge clk) begin
    if (w_data_wr) r_pix <= w_pix_nxt;
  end

  c2p_xpose #(.PIXELS(PIXELS), .PW(PW), .PXW(PXW)) u_xpose_rd (
    .i_ptr   (r_rptr),
    .o_plane (w_rplane),
    .o_base  (w_rbase)
  );

  always_comb begin
    w_planar = '0;
    w_px8    = '0;
    for (int i = 0; i < 16; i++) begin
      w_px8          = 8'(r_pix[w_rbase + PXW'(i)]);
      w_planar[15-i] = w_px8[w_rplane];
    end
  end

`ifdef C2P_P2C_EN
  assign w_rdata = (w_mode == MODE_P2C)
                 ? {8'(r_pix[w_rpair]), 8'(r_pix[w_rpair | PXW'(1)])}
                 : w_planar;
`else
  assign w_rdata = w_planar;
`endif

  always_comb begin
    w_status                        = '0;
    w_status[ST_FULL]               = r_full;
    w_status[ST_OVF]                = r_ovf;
    w_status[ST_MODE]               = (w_mode == MODE_P2C);
    w_status[ST_RPTR +: ST_PTR_W]   = ST_PTR_W'(r_rptr);
    w_status[ST_WPTR +: ST_PTR_W]   = ST_PTR_W'(r_wptr);
  end

  always_comb begin
    dout = '0;
    if (cs) begin
      if (addr == REG_ID_HI)      dout = ID_HI;
      else if (addr == REG_ID_LO) dout = ID_LO;
      else if (addr == REG_CTRL)  dout = w_status;
      else if (w_data_sel)        dout = w_rdata;
    end
  end

  assign busy = (r_wptr != '0) | (r_rptr != '0);

endmodule
